// File: rtl/cp0_pkg.sv
// CP0 shared definitions: register addresses, ExcCodes, Status masks and commit event kinds.
package cp0_pkg;

    localparam logic [7:0] ADDR_BADVADDR = {5'd8,  3'd0};
    localparam logic [7:0] ADDR_COUNT    = {5'd9,  3'd0};
    localparam logic [7:0] ADDR_COMPARE  = {5'd11, 3'd0};
    localparam logic [7:0] ADDR_STATUS   = {5'd12, 3'd0};
    localparam logic [7:0] ADDR_CAUSE    = {5'd13, 3'd0};
    localparam logic [7:0] ADDR_EPC      = {5'd14, 3'd0};

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    // IM[15:8], EXL[1], IE[0] are writable; BEV (bit 22) is hard-wired to 1.
    localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
    localparam logic [31:0] STATUS_RESET = 32'h0040_0000;

    typedef enum logic [2:0] {
        EV_NONE,
        EV_INT,
        EV_EXC,
        EV_ERET,
        EV_MTC0
    } cp0_event_e;

    function automatic logic [31:0] restart_pc(input logic bd, input logic [31:0] pc);
        return bd ? pc - 32'd4 : pc;
    endfunction

endpackage

// File: rtl/cp0_regfile_if.sv
// Writeback-stage commit bus between the pipeline (master) and CP0 (slave).
interface cp0_regfile_if;
    logic        wb_valid;
    logic        mtc0;
    logic [7:0]  cp0_addr;
    logic [31:0] cp0_wdata;
    logic [31:0] cp0_rdata;
    logic        exc_req;
    logic [4:0]  exc_code;
    logic        exc_bd;
    logic [31:0] exc_pc;
    logic        badv_wen;
    logic [31:0] badv_addr;
    logic        eret;
    logic        flush;
    logic [31:0] flush_pc;

    modport master (
        output wb_valid, mtc0, cp0_addr, cp0_wdata, exc_req, exc_code, exc_bd,
               exc_pc, badv_wen, badv_addr, eret,
        input  cp0_rdata, flush, flush_pc
    );

    modport slave (
        input  wb_valid, mtc0, cp0_addr, cp0_wdata, exc_req, exc_code, exc_bd,
               exc_pc, badv_wen, badv_addr, eret,
        output cp0_rdata, flush, flush_pc
    );
endinterface

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer: prescaled Count, Compare match raises TI until Compare is rewritten.
module cp0_timer #(
    parameter int unsigned COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        count_wen,
    input  logic        compare_wen,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);

    logic        presc;
    logic        tick;
    logic [31:0] count_inc;

    assign tick      = (presc == 1'(COUNT_DIV - 1));
    assign count_inc = count + 32'd1;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            presc   <= 1'b0;
            count   <= '0;
            compare <= '0;
            ti      <= 1'b0;
        end else begin
            if (count_wen) begin
                count <= wdata;
                presc <= 1'b0;
            end else if (tick) begin
                count <= count_inc;
                presc <= 1'b0;
            end else begin
                presc <= presc + 1'b1;
            end

            // Compare write acknowledges the timer even if a match lands in the same cycle.
            if (compare_wen) begin
                compare <= wdata;
                ti      <= 1'b0;
            end else if (!count_wen && tick && (count_inc == compare)) begin
                ti <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cp0_regfile.sv
// MIPS32 CP0 register file and WB-stage exception controller.
// Optional Count/Compare timer is built only when CP0_TIMER_EN is defined.
module cp0_regfile
    import cp0_pkg::*;
#(
    parameter int unsigned NUM_HW_INT = 6,
    parameter int unsigned COUNT_DIV  = 2,
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
    input  logic                  clk,
    input  logic                  resetn,
    cp0_regfile_if.slave          bus,
    input  logic [NUM_HW_INT-1:0] ext_int,
    output logic                  int_pending,
    output logic [31:0]           status_o,
    output logic [31:0]           cause_o,
    output logic [31:0]           epc_o
);

    logic [31:0] status_q;
    logic        cause_bd_q;
    logic [1:0]  ip_sw_q;
    logic [5:0]  ip_hw_q;
    logic [4:0]  exc_code_q;
    logic [31:0] epc_q;
    logic [31:0] badv_q;

    logic [5:0]  ext_pad;
    logic [7:0]  cause_ip;
    logic [31:0] count_val;
    logic [31:0] compare_val;
    logic        ti;
    cp0_event_e  ev;

    always_comb begin
        ext_pad = '0;
        ext_pad[NUM_HW_INT-1:0] = ext_int;
    end

`ifdef CP0_TIMER_EN
    logic count_wen;
    logic compare_wen;

    assign count_wen   = (ev == EV_MTC0) && (bus.cp0_addr == ADDR_COUNT);
    assign compare_wen = (ev == EV_MTC0) && (bus.cp0_addr == ADDR_COMPARE);

    cp0_timer #(
        .COUNT_DIV (COUNT_DIV)
    ) u_timer (
        .clk         (clk),
        .resetn      (resetn),
        .count_wen   (count_wen),
        .compare_wen (compare_wen),
        .wdata       (bus.cp0_wdata),
        .count       (count_val),
        .compare     (compare_val),
        .ti          (ti)
    );
`else
    assign count_val   = '0;
    assign compare_val = '0;
    assign ti          = 1'b0;
`endif

    assign cause_ip    = {ip_hw_q[5] | ti, ip_hw_q[4:0], ip_sw_q};
    assign status_o    = status_q;
    assign cause_o     = {cause_bd_q, ti, 14'd0, cause_ip, 1'b0, exc_code_q, 2'b00};
    assign epc_o       = epc_q;
    assign int_pending = status_q[0] & ~status_q[1] & (|(status_q[15:8] & cause_ip));

    // Single winner per commit; reset suppresses every event.
    always_comb begin
        ev = EV_NONE;
        if (resetn && bus.wb_valid) begin
            if (int_pending)       ev = EV_INT;
            else if (bus.exc_req)  ev = EV_EXC;
            else if (bus.eret)     ev = EV_ERET;
            else if (bus.mtc0)     ev = EV_MTC0;
        end
    end

    always_comb begin
        bus.flush    = 1'b0;
        bus.flush_pc = '0;
        unique case (ev)
            EV_INT, EV_EXC: begin
                bus.flush    = 1'b1;
                bus.flush_pc = EXC_VECTOR;
            end
            EV_ERET: begin
                bus.flush    = 1'b1;
                bus.flush_pc = epc_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        bus.cp0_rdata = '0;
        unique case (bus.cp0_addr)
            ADDR_BADVADDR: bus.cp0_rdata = badv_q;
            ADDR_COUNT:    bus.cp0_rdata = count_val;
            ADDR_COMPARE:  bus.cp0_rdata = compare_val;
            ADDR_STATUS:   bus.cp0_rdata = status_q;
            ADDR_CAUSE:    bus.cp0_rdata = cause_o;
            ADDR_EPC:      bus.cp0_rdata = epc_q;
            default:       bus.cp0_rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            status_q   <= STATUS_RESET;
            cause_bd_q <= 1'b0;
            ip_sw_q    <= '0;
            ip_hw_q    <= '0;
            exc_code_q <= '0;
            epc_q      <= '0;
            badv_q     <= '0;
        end else begin
            ip_hw_q <= ext_pad;
            unique case (ev)
                EV_INT, EV_EXC: begin
                    exc_code_q  <= (ev == EV_INT) ? EXC_INT : bus.exc_code;
                    status_q[1] <= 1'b1;
                    // A nested exception must not clobber the outer restart point.
                    if (!status_q[1]) begin
                        epc_q      <= restart_pc(bus.exc_bd, bus.exc_pc);
                        cause_bd_q <= bus.exc_bd;
                    end
                    if (ev == EV_EXC && bus.badv_wen)
                        badv_q <= bus.badv_addr;
                end
                EV_ERET: status_q[1] <= 1'b0;
                EV_MTC0: begin
                    unique case (bus.cp0_addr)
                        ADDR_STATUS: status_q <= (bus.cp0_wdata & STATUS_WMASK)
                                               | (status_q & ~STATUS_WMASK);
                        ADDR_CAUSE:  ip_sw_q  <= bus.cp0_wdata[9:8];
                        ADDR_EPC:    epc_q    <= bus.cp0_wdata;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cp0_regfile.sv
// Directed table-driven bench for cp0_regfile; timer checks follow CP0_TIMER_EN.
module tb_cp0_regfile;
    import cp0_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic [5:0]  ext_int;
    logic        int_pending;
    logic [31:0] status_o, cause_o, epc_o;

    int unsigned tests = 0;
    int unsigned failed = 0;

    cp0_regfile_if bus ();

    cp0_regfile #(
        .NUM_HW_INT (6),
        .COUNT_DIV  (2),
        .EXC_VECTOR (32'hBFC0_0380)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .bus         (bus),
        .ext_int     (ext_int),
        .int_pending (int_pending),
        .status_o    (status_o),
        .cause_o     (cause_o),
        .epc_o       (epc_o)
    );

    always #5 clk = ~clk;

`ifdef CP0_TIMER_EN
    localparam logic [31:0] EXP_CNT5  = 32'd5;
    localparam logic [31:0] EXP_CMP10 = 32'd10;
`else
    localparam logic [31:0] EXP_CNT5  = 32'd0;
    localparam logic [31:0] EXP_CMP10 = 32'd0;
`endif

    typedef struct {
        string       nm;
        logic        wbv, mtc0, eret, exc;
        logic [4:0]  code;
        logic        bd;
        logic [31:0] pc;
        logic        bw;
        logic [31:0] badv;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [5:0]  ext;
        logic        e_int, e_flush;
        logic [31:0] e_fpc;
        logic [7:0]  raddr;
        logic [31:0] e_rd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string nm, logic wbv, logic mtc0, logic eret, logic exc,
                                logic [4:0] code, logic bd, logic [31:0] pc, logic bw,
                                logic [31:0] badv, logic [7:0] addr, logic [31:0] wdata,
                                logic [5:0] ext, logic e_int, logic e_flush,
                                logic [31:0] e_fpc, logic [7:0] raddr, logic [31:0] e_rd);
        vec_t v;
        v.nm = nm; v.wbv = wbv; v.mtc0 = mtc0; v.eret = eret; v.exc = exc;
        v.code = code; v.bd = bd; v.pc = pc; v.bw = bw; v.badv = badv;
        v.addr = addr; v.wdata = wdata; v.ext = ext; v.e_int = e_int;
        v.e_flush = e_flush; v.e_fpc = e_fpc; v.raddr = raddr; v.e_rd = e_rd;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle_bus();
        bus.wb_valid = 1'b0; bus.mtc0 = 1'b0; bus.eret = 1'b0; bus.exc_req = 1'b0;
        bus.exc_code = '0; bus.exc_bd = 1'b0; bus.exc_pc = '0; bus.badv_wen = 1'b0;
        bus.badv_addr = '0; bus.cp0_wdata = '0;
    endtask

    task automatic mtc0_commit(input logic [7:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        bus.wb_valid = 1'b1; bus.mtc0 = 1'b1; bus.cp0_addr = addr; bus.cp0_wdata = wdata;
        @(posedge clk);
        #1 idle_bus();
    endtask

    initial begin
        resetn = 1'b0;
        ext_int = '0;
        bus.cp0_addr = '0;
        idle_bus();
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;

        // Reset state
        #1;
        bus.cp0_addr = ADDR_STATUS; #1 check("rst_status", bus.cp0_rdata, 32'h0040_0000);
        bus.cp0_addr = ADDR_CAUSE;  #1 check("rst_cause", bus.cp0_rdata, 32'h0);
        bus.cp0_addr = ADDR_EPC;    #1 check("rst_epc", bus.cp0_rdata, 32'h0);
        check("rst_flush", {31'd0, bus.flush}, 32'd0);
        check("rst_flush_pc", bus.flush_pc, 32'h0);
        check("rst_int_pending", {31'd0, int_pending}, 32'd0);

        //              name       wbv mtc eret exc code      bd pc            bw badv          addr          wdata         ext    int fl fpc           raddr          rdata
        vecs.push_back(mk("sys_exc",   1, 0, 0, 1, EXC_SYS,  0, 32'hBFC0_0100, 0, 32'h0,        8'h0,         32'h0,        6'h00, 0, 1, 32'hBFC0_0380, ADDR_EPC,      32'hBFC0_0100));
        vecs.push_back(mk("sys_cause", 0, 0, 0, 0, 5'd0,     0, 32'h0,         0, 32'h0,        8'h0,         32'h0,        6'h00, 0, 0, 32'h0,         ADDR_CAUSE,    32'h0000_0020));
        vecs.push_back(mk("exl_set",   0, 0, 0, 0, 5'd0,     0, 32'h0,         0, 32'h0,        8'h0,         32'h0,        6'h00, 0, 0, 32'h0,         ADDR_STATUS,   32'h0040_0002));
        vecs.push_back(mk("nest_exc",  1, 0, 0, 1, EXC_ADEL, 1, 32'h8000_0010, 1, 32'hDEAD_BEE1, 8'h0,         32'h0,        6'h00, 0, 1, 32'hBFC0_0380, ADDR_EPC,      32'hBFC0_0100));
        vecs.push_back(mk("nest_cause",0, 0, 0, 0, 5'd0,     0, 32'h0,         0, 32'h0,        8'h0,         32'h0,        6'h00, 0, 0, 32'h0,         ADDR_CAUSE,    32'h0000_0010));
        vecs.push_back(mk("badvaddr",  0, 0, 0, 0, 5'd0,     0, 32'h0,         0, 32'h0,        8'h0,         32'h0,        6'h00, 0, 0, 32'h0,         ADDR_BADVADDR, 32'hDEAD_BEE1));
        vecs.push_back(mk("eret",      1, 0, 1, 0, 5'd0,     0, 32'h0,         0, 32'h0,        8'h0,         32'h0,        6'h00, 0, 1, 32'hBFC0_0100, ADDR_STATUS,   32'h0040_0000));
        vecs.push_back(mk("eret_mtc0", 1, 1, 1, 0, 5'd0,     0, 32'h0,         0, 32'h0,        ADDR_STATUS,  32'h0000_0401, 6'h00, 0, 1, 32'hBFC0_0100, ADDR_STATUS,   32'h0040_0000));
        vecs.push_back(mk("mtc_status",1, 1, 0, 0, 5'd0,     0, 32'h0,         0, 32'h0,        ADDR_STATUS,  32'h0000_0401, 6'h00, 0, 0, 32'h0,         ADDR_STATUS,   32'h0040_0401));
        vecs.push_back(mk("mtc_epc",   1, 1, 0, 0, 5'd0,     0, 32'h0,         0, 32'h0,        ADDR_EPC,     32'h1234_5678, 6'h00, 0, 0, 32'h0,         ADDR_EPC,      32'h1234_5678));
        vecs.push_back(mk("mtc_unmap", 1, 1, 0, 0, 5'd0,     0, 32'h0,         0, 32'h0,        {5'd15,3'd0}, 32'hFFFF_FFFF, 6'h00, 0, 0, 32'h0,         {5'd15,3'd0},  32'h0));
        vecs.push_back(mk("mtc_cause", 1, 1, 0, 0, 5'd0,     0, 32'h0,         0, 32'h0,        ADDR_CAUSE,   32'hFFFF_FFFF, 6'h00, 0, 0, 32'h0,         ADDR_CAUSE,    32'h0000_0310));
        vecs.push_back(mk("clr_cause", 1, 1, 0, 0, 5'd0,     0, 32'h0,         0, 32'h0,        ADDR_CAUSE,   32'h0,        6'h00, 0, 0, 32'h0,         ADDR_CAUSE,    32'h0000_0010));
        vecs.push_back(mk("ip_reg",    0, 0, 0, 0, 5'd0,     0, 32'h0,         0, 32'h0,        8'h0,         32'h0,        6'h01, 0, 0, 32'h0,         ADDR_CAUSE,    32'h0000_0410));
        vecs.push_back(mk("int_wins",  1, 0, 0, 1, EXC_OV,   1, 32'h8000_0100, 0, 32'h0,        8'h0,         32'h0,        6'h01, 1, 1, 32'hBFC0_0380, ADDR_EPC,      32'h8000_00FC));
        vecs.push_back(mk("int_cause", 0, 0, 0, 0, 5'd0,     0, 32'h0,         0, 32'h0,        8'h0,         32'h0,        6'h01, 0, 0, 32'h0,         ADDR_CAUSE,    32'h8000_0400));
        vecs.push_back(mk("int_eret",  1, 0, 1, 0, 5'd0,     0, 32'h0,         0, 32'h0,        8'h0,         32'h0,        6'h00, 0, 1, 32'h8000_00FC, ADDR_STATUS,   32'h0040_0401));
        vecs.push_back(mk("ip_clear",  0, 0, 0, 0, 5'd0,     0, 32'h0,         0, 32'h0,        8'h0,         32'h0,        6'h00, 0, 0, 32'h0,         ADDR_CAUSE,    32'h8000_0000));
        vecs.push_back(mk("mtc_count", 1, 1, 0, 0, 5'd0,     0, 32'h0,         0, 32'h0,        ADDR_COUNT,   32'd5,        6'h00, 0, 0, 32'h0,         ADDR_COUNT,    EXP_CNT5));
        vecs.push_back(mk("mtc_cmp",   1, 1, 0, 0, 5'd0,     0, 32'h0,         0, 32'h0,        ADDR_COMPARE, 32'd10,       6'h00, 0, 0, 32'h0,         ADDR_COMPARE,  EXP_CMP10));
        vecs.push_back(mk("ip7_ext",   0, 0, 0, 0, 5'd0,     0, 32'h0,         0, 32'h0,        8'h0,         32'h0,        6'h20, 0, 0, 32'h0,         ADDR_CAUSE,    32'h8000_8000));
        vecs.push_back(mk("ip7_clear", 0, 0, 0, 0, 5'd0,     0, 32'h0,         0, 32'h0,        8'h0,         32'h0,        6'h00, 0, 0, 32'h0,         ADDR_CAUSE,    32'h8000_0000));

        foreach (vecs[i]) begin
            @(negedge clk);
            bus.wb_valid = vecs[i].wbv; bus.mtc0 = vecs[i].mtc0; bus.eret = vecs[i].eret;
            bus.exc_req = vecs[i].exc; bus.exc_code = vecs[i].code; bus.exc_bd = vecs[i].bd;
            bus.exc_pc = vecs[i].pc; bus.badv_wen = vecs[i].bw; bus.badv_addr = vecs[i].badv;
            bus.cp0_addr = vecs[i].addr; bus.cp0_wdata = vecs[i].wdata; ext_int = vecs[i].ext;
            #1;
            check({vecs[i].nm, "_int"}, {31'd0, int_pending}, {31'd0, vecs[i].e_int});
            check({vecs[i].nm, "_flush"}, {31'd0, bus.flush}, {31'd0, vecs[i].e_flush});
            check({vecs[i].nm, "_fpc"}, bus.flush_pc, vecs[i].e_fpc);
            @(posedge clk);
            #1 idle_bus();
            bus.cp0_addr = vecs[i].raddr;
            #1 check({vecs[i].nm, "_rd"}, bus.cp0_rdata, vecs[i].e_rd);
        end

`ifdef CP0_TIMER_EN
        // Compare=10 then Count=0: with /2 prescale, TI appears on the 20th edge after the Count write.
        mtc0_commit(ADDR_COMPARE, 32'd10);
        mtc0_commit(ADDR_COUNT, 32'd0);
        bus.cp0_addr = ADDR_COUNT;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (n == 19) begin
                check("tmr_cnt19", bus.cp0_rdata, 32'd9);
                check("tmr_ti19", {31'd0, cause_o[30]}, 32'd0);
            end
            if (n == 20) begin
                check("tmr_cnt20", bus.cp0_rdata, 32'd10);
                check("tmr_ti20", {31'd0, cause_o[30]}, 32'd1);
                check("tmr_ip7", {31'd0, cause_o[15]}, 32'd1);
            end
        end
        mtc0_commit(ADDR_COMPARE, 32'd10);
        check("tmr_ti_clr", {31'd0, cause_o[30]}, 32'd0);
`else
        mtc0_commit(ADDR_COUNT, 32'd5);
        repeat (30) @(posedge clk);
        #1 bus.cp0_addr = ADDR_COUNT;
        #1 check("notmr_count", bus.cp0_rdata, 32'd0);
        check("notmr_ti", {31'd0, cause_o[30]}, 32'd0);
`endif

        // Reset asserted alongside a committing exception: reset wins.
        @(negedge clk);
        resetn = 1'b0;
        bus.wb_valid = 1'b1; bus.exc_req = 1'b1; bus.exc_code = EXC_BP;
        bus.exc_pc = 32'h8000_0200;
        #1;
        check("rstov_flush", {31'd0, bus.flush}, 32'd0);
        check("rstov_fpc", bus.flush_pc, 32'h0);
        @(posedge clk);
        #1 resetn = 1'b1;
        idle_bus();
        #1;
        check("rstov_status", status_o, 32'h0040_0000);
        check("rstov_cause", cause_o, 32'h0);
        check("rstov_epc", epc_o, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/cp0_regfile.md
# cp0_regfile

Parametrised MIPS32 coprocessor-0 register file and exception controller that sits beside the writeback stage. It holds Status, Cause, EPC, BadVAddr, Count and Compare, arbitrates interrupt, exception, eret and mtc0 events committed in WB, and drives the pipeline flush and redirect PC. It generalises hardware-interrupt width, timer rate and exception vector, and adds nested-exception (EXL) protection and a dedicated timer sub-block.

## Interface
- NUM_HW_INT, 6: hardware interrupt lines (1..6); ext_int[i] maps to Cause.IP[2+i].
- COUNT_DIV, 2: Count increments once every COUNT_DIV cycles (1 or 2).
- EXC_VECTOR, 32'hBFC0_0380: redirect target for interrupts and exceptions.
- clk  in  1  clock.
- resetn  in  1  reset; synchronous, active-low.
- wb_valid  in  1  instruction in WB commits this cycle.
- mtc0  in  1  WB instruction is MTC0.
- cp0_addr  in  8  {rd[4:0], sel[2:0]}.
- cp0_wdata  in  32  MTC0 data.
- cp0_rdata  out  32  combinational MFC0 read of cp0_addr.
- exc_req  in  1  WB instruction raised a synchronous exception.
- exc_code  in  5  ExcCode for exc_req.
- exc_bd  in  1  WB instruction is in a branch delay slot.
- exc_pc  in  32  PC of WB instruction.
- badv_wen  in  1  exception carries a bad address.
- badv_addr  in  32  faulting address.
- eret  in  1  WB instruction is ERET.
- ext_int  in  NUM_HW_INT  level-sensitive hardware interrupts.
- int_pending  out  1  an enabled interrupt is pending.
- flush  out  1  cancel pipeline and redirect.
- flush_pc  out  32  redirect target.
- status_o, cause_o, epc_o  out  32  register values.

## Operation
- Addresses: BadVAddr {8,0}, Count {9,0}, Compare {11,0}, Status {12,0}, Cause {13,0}, EPC {14,0}; others read 0, writes ignored.
- Status: BEV bit22 reads 1 (not writable); IM[15:8], EXL[1], IE[0] writable; other bits read 0.
- Cause: BD[31], TI[30], IP[15:8], ExcCode[6:2]; only IP[1:0] software-writable. IP[7:2] registered each cycle from ext_int (unused lines 0); IP7 = ext_int[5] | TI.
- int_pending = IE & ~EXL & |(IM & IP).
- Commit priority when wb_valid: interrupt (int_pending) > exc_req > eret > mtc0. Only the winner takes effect; lower events are dropped.
- Interrupt/exception: ExcCode = 0 or exc_code; EXL<=1; if EXL was 0: EPC <= exc_bd ? exc_pc-4 : exc_pc, BD <= exc_bd; if EXL was 1, EPC and BD keep their values. BadVAddr <= badv_addr only for exception with badv_wen. flush=1, flush_pc=EXC_VECTOR.
- eret: EXL<=0, flush=1, flush_pc=EPC (current registered value).
- mtc0 to Compare clears TI.
- Reset: Status 0x0040_0000, Cause/EPC/BadVAddr/Count/Compare 0, flush 0, int_pending 0, flush_pc 0.

## Timing
- cp0_rdata, int_pending, flush, flush_pc combinational from registers and WB inputs; all register updates on the next clk edge.
- Count: prescaler increments Count when it wraps; mtc0 Count loads value and resets prescaler, overriding increment.
- TI sets on the cycle Count==Compare after an increment; Compare write in the same cycle wins (TI cleared).
- ext_int to int_pending: one cycle (IP register).
- MFC0 after MTC0 to same register in consecutive cycles returns new value.
- resetn low overrides every event, including a commit in the same cycle.

## Configuration
- CP0_TIMER_EN defined: Count/Compare/TI implemented as above.
- Undefined: Count and Compare read 0, writes ignored, TI constant 0, IP7 = ext_int[5] only; cp0_timer not instantiated.

## Structure
- Package cp0_pkg: register address constants, ExcCode constants (INT 0, ADEL 4, ADES 5, SYS 8, BP 9, RI 10, OV 12), STATUS_WMASK, STATUS_RESET.
- Sub-module cp0_timer: Count, Compare, prescaler and TI generation.

## Test plan
- Reset, read Status -> 0x0040_0000; Cause, EPC -> 0.
- exc_req code 8, exc_pc 0xBFC0_0100, bd 0 -> flush, flush_pc 0xBFC0_0380, EPC 0xBFC0_0100, Cause[6:2]=8, EXL=1.
- Second exception while EXL=1, bd 1 -> EPC unchanged, ExcCode updated; then eret -> flush_pc 0xBFC0_0100, EXL=0.
- Status=0x0000_0401, ext_int[0]=1, wb_valid with exc_req -> interrupt wins, ExcCode 0.
- COUNT_DIV=2, Compare=10, Count=0 -> TI and IP7 set after 20 cycles; mtc0 Compare clears TI.
- Without CP0_TIMER_EN, mtc0 Count 5 -> read Count 0, TI stays 0.
